// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB receive sequencer slice.
//   state_e    : sequencer FSM states
//   line_e     : sampled line code {dp,dm}
//   rx_ev_e    : per-sample decision reported by the next-state logic
//   SYNC_RAW   : raw dp pattern of KJKJKJKK, oldest bit in the MSB
//   SHREG_IDLE : sync shift register contents for an idle (J) line
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    RECV,
    EOP1,
    EOP2
  } state_e;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_DONE,
    EV_TIMEOUT,
    EV_ERROR,
    EV_CANCEL
  } rx_ev_e;

  localparam logic [7:0] SYNC_RAW   = 8'b0101_0100;
  localparam logic [7:0] SHREG_IDLE = 8'hFF;

  // J and K carry data; SE0/SE1 are line states.
  function automatic logic is_data(input line_e l);
    return (l == LINE_J) || (l == LINE_K);
  endfunction

endpackage

// File: rtl/usb_rx_sequencer_if.sv
// usb_rx_sequencer_if: line inputs, protocol handshake and status outputs of the
// receive sequencer.
//   rx_en, dp, dm, stuff_err            : driven by line / protocol side (master)
//   start_rc_nrzi, end_rc_nrzi, abort,
//   rx_active, rx_done, rx_timeout,
//   rx_error, bit_cnt                   : driven by the sequencer (slave)
interface usb_rx_sequencer_if #(
  parameter int unsigned CNT_W = 11
) ();

  logic             rx_en;
  logic             dp;
  logic             dm;
  logic             stuff_err;
  logic             start_rc_nrzi;
  logic             end_rc_nrzi;
  logic             abort;
  logic             rx_active;
  logic             rx_done;
  logic             rx_timeout;
  logic             rx_error;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output rx_en, dp, dm, stuff_err,
    input  start_rc_nrzi, end_rc_nrzi, abort, rx_active,
           rx_done, rx_timeout, rx_error, bit_cnt
  );

  modport slave (
    input  rx_en, dp, dm, stuff_err,
    output start_rc_nrzi, end_rc_nrzi, abort, rx_active,
           rx_done, rx_timeout, rx_error, bit_cnt
  );

endinterface

// File: rtl/usb_sync_detect.sv
// usb_sync_detect: 8-bit SYNC hunter.
//   clk, rst   : bit clock, synchronous active-high reset
//   clr_i      : reload register with the idle pattern (takes priority)
//   shift_i    : shift bit_i in as the newest (LSB) bit
//   bit_i      : sampled dp
//   match_o    : combinational; the register including this sample equals SYNC_RAW
module usb_sync_detect
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic shift_i,
  input  logic bit_i,
  output logic match_o
);

  logic [7:0] shreg_q;
  logic [7:0] shreg_d;
  logic [7:0] shifted;

  assign shifted = {shreg_q[6:0], bit_i};

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = SHREG_IDLE;
    end else if (shift_i) begin
      shreg_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= SHREG_IDLE;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Looks at the incoming sample so the FSM can act on the last K itself.
  assign match_o = shift_i && !clr_i && (shifted == SYNC_RAW);

endmodule

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer: receive-side sequencer between the USB line and the NRZI decoder.
// Hunts SYNC, counts payload bits, validates EOP and reports done/timeout/error.
//   clk, rst : bit-rate clock, synchronous active-high reset
//   rx       : usb_rx_sequencer_if.slave
//              in : rx_en, dp, dm, stuff_err
//              out: start_rc_nrzi, end_rc_nrzi, abort, rx_active, rx_done,
//                   rx_timeout, rx_error, bit_cnt (all registered)
module usb_rx_sequencer
  import usb_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_BITS = 255,
  parameter int unsigned MAX_BITS     = 1100,
  parameter int unsigned CNT_W        = 11
) (
  input logic              clk,
  input logic              rst,
  usb_rx_sequencer_if.slave rx
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BITS - 1);

  state_e           state_q, state_d;
  rx_ev_e           ev;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             abort_q, abort_d;
  logic             active_q, active_d;
  logic             timeout_q, timeout_d;
  logic             error_q, error_d;

  line_e            line_s;
  logic             data_s;
  logic             sync_match;

  assign line_s = line_e'({rx.dp, rx.dm});
  assign data_s = is_data(line_s);

  usb_sync_detect u_sync (
    .clk     (clk),
    .rst     (rst),
    .clr_i   ((state_q != HUNT) || !data_s),
    .shift_i ((state_q == HUNT) && data_s),
    .bit_i   (rx.dp),
    .match_o (sync_match)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      abort_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      end_q     <= end_d;
      abort_q   <= abort_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  // Next state; branch order encodes rx_en drop > error > EOP > SYNC/count.
  always_comb begin
    state_d = state_q;
    ev      = EV_NONE;
    unique case (state_q)
      IDLE: begin
        if (rx.rx_en) state_d = HUNT;
      end
      HUNT: begin
        if (!rx.rx_en) begin
          state_d = IDLE;
        end else if (sync_match) begin
          state_d = RECV;
          ev      = EV_START;
        end else if (timer_q == TMO_LAST) begin
          state_d = IDLE;
          ev      = EV_TIMEOUT;
        end
      end
      RECV: begin
        if (!rx.rx_en) begin
          state_d = IDLE;
          ev      = EV_CANCEL;
        end else if ((line_s == LINE_SE1) || rx.stuff_err ||
                     (data_s && (bit_cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          ev      = EV_ERROR;
        end else if (line_s == LINE_SE0) begin
          state_d = EOP1;
        end
      end
      EOP1: begin
        if (!rx.rx_en) begin
          state_d = IDLE;
          ev      = EV_CANCEL;
        end else if (line_s == LINE_SE0) begin
          state_d = EOP2;
        end else begin
          state_d = IDLE;
          ev      = EV_ERROR;
        end
      end
      EOP2: begin
        state_d = IDLE;
        if (!rx.rx_en) begin
          ev = EV_CANCEL;
        end else if (line_s == LINE_J) begin
          ev = EV_DONE;
        end else begin
          ev = EV_ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and registered output values.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    unique case (state_q)
      IDLE: begin
        if (rx.rx_en) begin
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      HUNT: timer_d = timer_q + 1'b1;
      RECV: begin
        // The babble sample still counts so bit_cnt lands on MAX_BITS; a
        // stuff error does not.
        if (rx.rx_en && data_s && !rx.stuff_err) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: ;
    endcase

    start_d   = (ev == EV_START);
    end_d     = (ev == EV_DONE);
    timeout_d = (ev == EV_TIMEOUT);
    error_d   = (ev == EV_ERROR);
    abort_d   = (ev == EV_ERROR) || (ev == EV_CANCEL);
    active_d  = (state_d == RECV) || (state_d == EOP1) || (state_d == EOP2);
  end

  assign rx.start_rc_nrzi = start_q;
  assign rx.end_rc_nrzi   = end_q;
  assign rx.rx_done       = end_q;
  assign rx.abort         = abort_q;
  assign rx.rx_error      = error_q;
  assign rx.rx_timeout    = timeout_q;
  assign rx.rx_active     = active_q;
  assign rx.bit_cnt       = bit_cnt_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// tb_usb_rx_sequencer: directed self-checking bench for usb_rx_sequencer
// (TIMEOUT_BITS=255, MAX_BITS=20).
module tb_usb_rx_sequencer;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  // Flag vector order: start, end, abort, active, done, timeout, error
  localparam logic [31:0] F_NONE  = 32'h00;
  localparam logic [31:0] F_START = 32'h40;
  localparam logic [31:0] F_END   = 32'h20;
  localparam logic [31:0] F_ABORT = 32'h10;
  localparam logic [31:0] F_ACT   = 32'h08;
  localparam logic [31:0] F_DONE  = 32'h04;
  localparam logic [31:0] F_TMO   = 32'h02;
  localparam logic [31:0] F_ERR   = 32'h01;

  localparam logic [7:0] SYNC_OK  = 8'b0101_0100;
  localparam logic [7:0] SYNC_BAD = 8'b0101_0110;

  logic        clk;
  logic        rst;
  logic [6:0]  flg;
  logic [6:0]  early;
  logic [15:0] pat = 16'hA5C3;
  int          n_vec = 0;
  int          n_err = 0;

  usb_rx_sequencer_if #(.CNT_W(11)) bus ();

  usb_rx_sequencer #(
    .TIMEOUT_BITS (255),
    .MAX_BITS     (20),
    .CNT_W        (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  assign flg = {bus.start_rc_nrzi, bus.end_rc_nrzi, bus.abort, bus.rx_active,
                bus.rx_done, bus.rx_timeout, bus.rx_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one line sample, let the DUT take it, settle past the edge.
  task automatic drive(input logic [1:0] code);
    {bus.dp, bus.dm} = code;
    @(posedge clk);
    #1;
  endtask

  // First n bits of raw, MSB first; 1 -> J, 0 -> K.
  task automatic send_bits(input logic [7:0] raw, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(raw[7-i] ? J : K);
  endtask

  task automatic payload(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(pat[i % 16] ? J : K);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_en = 1'b0;
    bus.stuff_err = 1'b0;
    drive(J);
    drive(J);
    chk("reset_flags", 32'(flg), F_NONE);
    chk("reset_bitcnt", 32'(bus.bit_cnt), 0);
    rst = 1'b0;

    // 1: reset held mid-RECV
    bus.rx_en = 1'b1;
    drive(J);
    send_bits(SYNC_OK, 8);
    chk("t1_start", 32'(flg), F_START | F_ACT);
    payload(3);
    chk("t1_cnt3", 32'(bus.bit_cnt), 3);
    rst = 1'b1;
    drive(K);
    chk("t1_rst_c1", 32'(flg), F_NONE);
    chk("t1_rst_cnt", 32'(bus.bit_cnt), 0);
    drive(K);
    chk("t1_rst_c2", 32'(flg), F_NONE);
    drive(K);
    chk("t1_rst_c3", 32'(flg), F_NONE);
    rst = 1'b0;
    bus.rx_en = 1'b0;
    drive(J);
    chk("t1_post", 32'(flg), F_NONE);

    // 2: clean 16-bit packet
    bus.rx_en = 1'b1;
    repeat (5) drive(J);
    send_bits(SYNC_OK, 7);
    chk("t2_no_early", 32'(flg), F_NONE);
    drive(K);
    chk("t2_start", 32'(flg), F_START | F_ACT);
    payload(1);
    chk("t2_start_1cyc", 32'(flg), F_ACT);
    payload(15);
    chk("t2_cnt16", 32'(bus.bit_cnt), 16);
    drive(SE0);
    chk("t2_eop1", 32'(flg), F_ACT);
    drive(SE0);
    chk("t2_eop2", 32'(flg), F_ACT);
    drive(J);
    chk("t2_done", 32'(flg), F_END | F_DONE);
    chk("t2_cnt_hold", 32'(bus.bit_cnt), 16);
    bus.rx_en = 1'b0;
    drive(J);
    chk("t2_idle", 32'(flg), F_NONE);
    chk("t2_cnt_hold2", 32'(bus.bit_cnt), 16);

    // 3: timeout after 255 HUNT samples
    bus.rx_en = 1'b1;
    drive(J);
    chk("t3_cnt_clear", 32'(bus.bit_cnt), 0);
    early = '0;
    repeat (254) begin
      drive(J);
      early |= flg;
    end
    chk("t3_no_early", 32'(early), F_NONE);
    drive(J);
    chk("t3_timeout", 32'(flg), F_TMO);
    bus.rx_en = 1'b0;
    drive(J);
    chk("t3_idle", 32'(flg), F_NONE);

    // 4: stuff error on payload bit 9, then bad EOP
    bus.rx_en = 1'b1;
    drive(J);
    send_bits(SYNC_OK, 8);
    payload(8);
    chk("t4_cnt8", 32'(bus.bit_cnt), 8);
    bus.stuff_err = 1'b1;
    drive(J);
    chk("t4_stuff", 32'(flg), F_ABORT | F_ERR);
    chk("t4_stuff_cnt", 32'(bus.bit_cnt), 8);
    bus.stuff_err = 1'b0;
    drive(J);
    chk("t4_no_end", 32'(flg), F_NONE);
    send_bits(SYNC_OK, 8);
    payload(4);
    drive(SE0);
    chk("t4_eop1", 32'(flg), F_ACT);
    drive(J);
    chk("t4_short_eop", 32'(flg), F_ABORT | F_ERR);

    // 5: cancel mid-RECV, near-miss SYNC, silent HUNT cancel
    drive(J);
    send_bits(SYNC_OK, 8);
    payload(5);
    bus.rx_en = 1'b0;
    drive(K);
    chk("t5_cancel", 32'(flg), F_ABORT);
    chk("t5_cancel_cnt", 32'(bus.bit_cnt), 5);
    bus.rx_en = 1'b1;
    drive(J);
    send_bits(SYNC_BAD, 8);
    chk("t5_bad_sync", 32'(flg), F_NONE);
    drive(J);
    drive(J);
    bus.rx_en = 1'b0;
    drive(J);
    chk("t5_hunt_cancel", 32'(flg), F_NONE);
    bus.rx_en = 1'b1;
    drive(J);
    send_bits(SYNC_OK, 7);
    bus.rx_en = 1'b0;
    drive(K);
    chk("t5_drop_on_match", 32'(flg), F_NONE);
    drive(J);
    chk("t5_not_recv", 32'(flg), F_NONE);

    // 6: babble at MAX_BITS, back-to-back packets
    bus.rx_en = 1'b1;
    drive(J);
    send_bits(SYNC_OK, 8);
    payload(19);
    chk("t6_cnt19", 32'(bus.bit_cnt), 19);
    chk("t6_act19", 32'(flg), F_ACT);
    drive(J);
    chk("t6_babble", 32'(flg), F_ABORT | F_ERR);
    chk("t6_cnt20", 32'(bus.bit_cnt), 20);
    payload(5);
    chk("t6_tail", 32'(flg), F_NONE);
    send_bits(SYNC_OK, 7);
    drive(SE1);
    drive(K);
    chk("t6_se1_clears", 32'(flg), F_NONE);
    send_bits(SYNC_OK, 8);
    chk("t6_a_start", 32'(flg), F_START | F_ACT);
    payload(3);
    drive(SE0);
    drive(SE0);
    drive(J);
    chk("t6_a_done", 32'(flg), F_END | F_DONE);
    chk("t6_a_cnt", 32'(bus.bit_cnt), 3);
    drive(J);
    chk("t6_rearm", 32'(flg), F_NONE);
    chk("t6_rearm_cnt", 32'(bus.bit_cnt), 0);
    send_bits(SYNC_OK, 8);
    chk("t6_b_start", 32'(flg), F_START | F_ACT);
    payload(2);
    drive(SE0);
    drive(SE0);
    drive(J);
    chk("t6_b_done", 32'(flg), F_END | F_DONE);
    chk("t6_b_cnt", 32'(bus.bit_cnt), 2);

    // SE1 inside payload, and a third SE0 in EOP2
    drive(J);
    send_bits(SYNC_OK, 8);
    payload(1);
    drive(SE1);
    chk("t6_se1_err", 32'(flg), F_ABORT | F_ERR);
    chk("t6_se1_cnt", 32'(bus.bit_cnt), 1);
    drive(J);
    send_bits(SYNC_OK, 8);
    payload(1);
    drive(SE0);
    drive(SE0);
    drive(SE0);
    chk("t6_se0x3", 32'(flg), F_ABORT | F_ERR);
    bus.rx_en = 1'b0;
    drive(J);
    chk("t6_final_idle", 32'(flg), F_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
